// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, register-file constants and the ALU
// operation encoding, so the register file and the ALU size themselves from one place.
package cpu_pkg;

   localparam int DATA_W_DEFAULT = 32;
   localparam int ADDR_W_DEFAULT = 5;
   localparam int NUM_REGS       = 2 ** ADDR_W_DEFAULT;
   localparam int REG_ZERO       = 0;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_SLT = 4'd5,
      ALU_SLL = 4'd6,
      ALU_SRL = 4'd7
   } alu_op_e;

endpackage

// File: rtl/reg_read_port.sv
// One combinational register-file read port; index zero always returns zero.
module reg_read_port
   import cpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] regs [2**ADDR_W],
   output logic [DATA_W-1:0] data
);

   always_comb begin
      data = '0;
      if (addr != ADDR_W'(REG_ZERO)) begin
         data = regs[addr];
      end
   end

endmodule

// File: rtl/reg_file.sv
// Architectural register file: 2**ADDR_W entries, two operand read ports plus a
// debug port, one write per clock, no write-to-read bypass.
module reg_file
   import cpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ra_addr,
   output logic [DATA_W-1:0] ra_data,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [DATA_W-1:0] rb_data,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa_addr,
   input  logic [DATA_W-1:0] wd_data,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int NREGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [NREGS];

   // Entry 0 is cleared by reset and never written, so the array stays
   // consistent with the read ports' zero forcing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (wa_addr != ADDR_W'(REG_ZERO))) begin
         regs[wa_addr] <= wd_data;
      end
   end

   reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
      .addr (ra_addr),
      .regs (regs),
      .data (ra_data)
   );

   reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
      .addr (rb_addr),
      .regs (regs),
      .data (rb_data)
   );

   reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_dbg (
      .addr (dbg_addr),
      .regs (regs),
      .data (dbg_data)
   );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, write/read, r0 protection,
// no-bypass ordering, asynchronous reset mid-cycle and we=0 hold.
module tb_reg_file;

   logic        clk;
   logic        rst_n;
   logic [4:0]  ra_addr;
   logic [31:0] ra_data;
   logic [4:0]  rb_addr;
   logic [31:0] rb_data;
   logic        we;
   logic [4:0]  wa_addr;
   logic [31:0] wd_data;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   logic [31:0] model [32];
   int          checks;
   int          errors;

   reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ra_addr  (ra_addr),
      .ra_data  (ra_data),
      .rb_addr  (rb_addr),
      .rb_data  (rb_data),
      .we       (we),
      .wa_addr  (wa_addr),
      .wd_data  (wd_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One full write cycle driven from the falling edge; the model follows the
   // architectural rule that writes to index 0 are dropped.
   task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      we      = w;
      wa_addr = a;
      wd_data = d;
      @(negedge clk);
      we = 1'b0;
      if (w && a != 5'd0) model[a] = d;
   endtask

   task automatic sweepDbg(input string tag);
      for (int i = 0; i < 32; i++) begin
         dbg_addr = 5'(i);
         #1;
         checkOutput($sformatf("%s_r%0d", tag, i), dbg_data, model[i]);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      we       = 1'b0;
      wa_addr  = 5'd0;
      wd_data  = 32'd0;
      ra_addr  = 5'd5;
      rb_addr  = 5'd31;
      dbg_addr = 5'd0;
      for (int i = 0; i < 32; i++) model[i] = 32'd0;

      // Reset state on every port
      #1;
      checkOutput("reset_ra", ra_data, 32'd0);
      checkOutput("reset_rb", rb_data, 32'd0);
      sweepDbg("reset_dbg");
      @(negedge clk);
      rst_n = 1'b1;

      // Write/read and the downstream subtract result
      applyStimulus(1'b1, 5'd1, 32'h0000_0005);
      ra_addr = 5'd1;
      #1;
      checkOutput("wr_ra_r1", ra_data, 32'h0000_0005);
      applyStimulus(1'b1, 5'd2, 32'hFFFF_FFFB);
      rb_addr = 5'd2;
      #1;
      checkOutput("wr_ra_r1_hold", ra_data, 32'h0000_0005);
      checkOutput("wr_rb_r2", rb_data, 32'hFFFF_FFFB);
      checkOutput("alu_sub", ra_data - rb_data, 32'h0000_000A);

      // r0 protection
      applyStimulus(1'b1, 5'd0, 32'hDEAD_BEEF);
      ra_addr = 5'd0;
      #1;
      checkOutput("r0_ra", ra_data, 32'd0);
      sweepDbg("r0_dbg");

      // No bypass: old value before the edge, new value after it
      applyStimulus(1'b1, 5'd3, 32'h0000_0011);
      @(negedge clk);
      we      = 1'b1;
      wa_addr = 5'd3;
      wd_data = 32'h0000_0022;
      ra_addr = 5'd3;
      rb_addr = 5'd3;
      #1;
      checkOutput("nobyp_ra_pre", ra_data, 32'h0000_0011);
      checkOutput("nobyp_rb_pre", rb_data, 32'h0000_0011);
      @(negedge clk);
      we       = 1'b0;
      model[3] = 32'h0000_0022;
      #1;
      checkOutput("nobyp_ra_post", ra_data, 32'h0000_0022);
      checkOutput("nobyp_rb_post", rb_data, 32'h0000_0022);

      // Back-to-back writes to one index: last write wins
      applyStimulus(1'b1, 5'd4, 32'h0000_AAAA);
      applyStimulus(1'b1, 5'd4, 32'h0000_BBBB);
      dbg_addr = 5'd4;
      #1;
      checkOutput("b2b_r4", dbg_data, 32'h0000_BBBB);

      // Fill r1..r31 with their indices, then reset mid-cycle with a write pending
      for (int i = 1; i < 32; i++) applyStimulus(1'b1, 5'(i), 32'(i));
      sweepDbg("fill");
      @(negedge clk);
      we       = 1'b1;
      wa_addr  = 5'd7;
      wd_data  = 32'h0000_0077;
      ra_addr  = 5'd7;
      rb_addr  = 5'd31;
      dbg_addr = 5'd15;
      #1;
      rst_n = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      #1;
      checkOutput("rstmid_ra_r7", ra_data, 32'd0);
      checkOutput("rstmid_rb_r31", rb_data, 32'd0);
      checkOutput("rstmid_dbg_r15", dbg_data, 32'd0);
      #1;
      we = 1'b0;
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rstmid_r7_after_edge", ra_data, 32'd0);
      sweepDbg("rstmid_sweep");

      // we=0 hold under random write address/data
      for (int i = 1; i < 32; i++) applyStimulus(1'b1, 5'(i), {8'(i), 8'hA5, 8'(31 - i), 8'h3C});
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         we      = 1'b0;
         wa_addr = 5'($urandom_range(0, 31));
         wd_data = $urandom;
      end
      @(negedge clk);
      sweepDbg("hold");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
